// File: rtl/piezo_mon_pkg.sv
// Shared register map, readdata field positions and FSM encoding for the piezo phase monitor.
package piezo_mon_pkg;

    localparam logic [6:0] ADDR_PERIOD = 7'h60;
    localparam logic [6:0] ADDR_STATUS = 7'h61;
    localparam logic [6:0] ADDR_CTRL   = 7'h62;

    localparam int RD_VALID_BIT = 31;
    localparam int ST_FRAME_LSB = 16;
    localparam int ST_STATE_LSB = 1;
    localparam int ST_LOST_BIT  = 0;
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REF = 2'd1,
        MEASURE  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/piezo_mon_channel.sv
// One monitored piezo line: synchroniser, rising-edge detect, first-edge capture
// within the current reference window and the published phase/valid pair.
module piezo_mon_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             piezo_in,
    input  logic [CNT_W-1:0] cnt,
    input  logic             ref_rise,
    input  logic             armed,
    input  logic             clear,
    input  logic             publish,
    output logic [CNT_W-1:0] phase_pub,
    output logic             valid_pub
);

    logic [2:0]       sync_q, sync_d;
    logic             rise_q, rise_d;
    logic             seen_q, seen_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] phase_q, phase_d;

    always_comb begin
        sync_d  = {sync_q[1:0], piezo_in};
        rise_d  = sync_q[1] & ~sync_q[2];
        seen_d  = seen_q;
        cap_d   = cap_q;
        phase_d = phase_q;
        valid_d = valid_q;
        if (publish) begin
            phase_d = cap_q;
            valid_d = seen_q;
        end
        // An edge coincident with the reference opens the new window at phase 0.
        if (clear) begin
            seen_d = 1'b0;
        end else if (ref_rise) begin
            seen_d = rise_q;
            if (rise_q) cap_d = '0;
        end else if (armed && rise_q && !seen_q) begin
            seen_d = 1'b1;
            cap_d  = cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            rise_q  <= 1'b0;
            seen_q  <= 1'b0;
            valid_q <= 1'b0;
            cap_q   <= '0;
            phase_q <= '0;
        end else begin
            sync_q  <= sync_d;
            rise_q  <= rise_d;
            seen_q  <= seen_d;
            valid_q <= valid_d;
            cap_q   <= cap_d;
            phase_q <= phase_d;
        end
    end

    assign phase_pub = phase_q;
    assign valid_pub = valid_q;

endmodule

// File: rtl/piezo_phase_monitor.sv
// Measures each piezo feedback line's rising-edge phase against the reference strobe
// and publishes a double-buffered result bank over an Avalon-MM slave.
//   state    | meaning
//   IDLE     | disabled; counter, seen flags and window cleared, bank held
//   WAIT_REF | enabled, waiting for a reference edge to open a window
//   MEASURE  | window open; capturing edges, each reference edge publishes
module piezo_phase_monitor
    import piezo_mon_pkg::*;
#(
    parameter int NUM_CH = 89,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] piezo_in,
    input  logic              ref_in,
    input  logic [6:0]        avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mon_state_t       state_q, state_d;
    logic [2:0]       ref_sync_q, ref_sync_d;
    logic             ref_rise_q, ref_rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_q, hold_d;
    logic             enable_q, enable_d;
    logic             ref_lost_q, ref_lost_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             frame_done_q, frame_done_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             armed, stopped, sat, clear, publish, ctrl_wr;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] phase_pub [NUM_CH];
    logic [NUM_CH-1:0] valid_pub;
    logic             wdata_unused;

    assign wdata_unused = ^avs_writedata[31:2];

    always_comb begin
        state_d = state_q;
        if (!enable_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = WAIT_REF;
                WAIT_REF: if (ref_rise_q) state_d = MEASURE;
                MEASURE:  if (sat) state_d = WAIT_REF;
                default:  state_d = IDLE;
            endcase
        end
    end

    // A reference edge wins over saturation in the same cycle.
    always_comb begin
        armed   = (state_q == MEASURE);
        stopped = !enable_q || (state_q == IDLE);
        sat     = armed && !ref_rise_q && (cnt_q == CNT_MAX);
        clear   = stopped || sat;
        publish = armed && enable_q && ref_rise_q;
        win_cnt = ref_rise_q ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        ref_sync_d   = {ref_sync_q[1:0], ref_in};
        ref_rise_d   = ref_sync_q[1] & ~ref_sync_q[2];
        cnt_d        = cnt_q + CNT_W'(1);
        hold_d       = hold_q;
        if (stopped || ref_rise_q) begin
            cnt_d  = '0;
            hold_d = 1'b0;
        end else if (sat) begin
            cnt_d  = '0;
            hold_d = 1'b1;
        end else if (hold_q) begin
            cnt_d  = '0;
        end
        ctrl_wr      = avs_write && (avs_address == ADDR_CTRL);
        enable_d     = ctrl_wr ? avs_writedata[CTRL_EN_BIT] : enable_q;
        ref_lost_d   = ref_lost_q | sat;
        frame_cnt_d  = frame_cnt_q + 16'(publish);
        if (ctrl_wr && avs_writedata[CTRL_CLR_BIT]) begin
            ref_lost_d  = 1'b0;
            frame_cnt_d = '0;
        end
        period_d     = publish ? cnt_q + CNT_W'(1) : period_q;
        frame_done_d = publish;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            if (avs_address < 7'(NUM_CH)) begin
                rdata_d[RD_VALID_BIT] = valid_pub[avs_address];
                rdata_d[CNT_W-1:0]    = phase_pub[avs_address];
            end else if (avs_address == ADDR_PERIOD) begin
                rdata_d[CNT_W-1:0] = period_q;
            end else if (avs_address == ADDR_STATUS) begin
                rdata_d[ST_FRAME_LSB +: 16] = frame_cnt_q;
                rdata_d[ST_STATE_LSB +: 2]  = state_q;
                rdata_d[ST_LOST_BIT]        = ref_lost_q;
            end else if (avs_address == ADDR_CTRL) begin
                rdata_d[CTRL_EN_BIT] = enable_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ref_sync_q   <= '0;
            ref_rise_q   <= 1'b0;
            cnt_q        <= '0;
            hold_q       <= 1'b0;
            enable_q     <= 1'b0;
            ref_lost_q   <= 1'b0;
            frame_cnt_q  <= '0;
            period_q     <= '0;
            frame_done_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            ref_sync_q   <= ref_sync_d;
            ref_rise_q   <= ref_rise_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            enable_q     <= enable_d;
            ref_lost_q   <= ref_lost_d;
            frame_cnt_q  <= frame_cnt_d;
            period_q     <= period_d;
            frame_done_q <= frame_done_d;
            rdata_q      <= rdata_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        piezo_mon_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .piezo_in  (piezo_in[i]),
            .cnt       (win_cnt),
            .ref_rise  (ref_rise_q),
            .armed     (armed),
            .clear     (clear),
            .publish   (publish),
            .phase_pub (phase_pub[i]),
            .valid_pub (valid_pub[i])
        );
    end

    assign avs_readdata = rdata_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_piezo_phase_monitor.sv
// Directed bench for piezo_phase_monitor: a free-running waveform generator drives the
// reference and channel lines; bus reads are checked against a queue of expected words.
module tb_piezo_phase_monitor;

    localparam int NUM_CH = 89;
    localparam int CNT_W  = 16;
    localparam int P      = 1250;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] piezo_in;
    logic              ref_in;
    logic [6:0]        avs_address;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              frame_done;

    int          tests = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    bit gen_on = 1'b0;
    bit ref_stop = 1'b0;
    int cyc = 0;
    int base = 0;
    int mon_cyc = 0;
    int fd_count = 0;
    int fd_last = 0;
    int fd_interval = 0;

    piezo_phase_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .piezo_in      (piezo_in),
        .ref_in        (ref_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // Rising-edge offset of each channel after the reference edge; -1 means never.
    function automatic int ch_off(input int i);
        case (i)
            0:       return 0;
            3:       return 200;
            5:       return 100;
            7:       return -1;
            88:      return P - 1;
            default: return (i * 13 + 7) % 1200;
        endcase
    endfunction

    function automatic bit ch_level(input int i, input int tp);
        int o = ch_off(i);
        int w;
        if (o < 0) return 1'b0;
        if (i == 3) return (tp >= 200 && tp < 250) || (tp >= 600 && tp < 650);
        w = (P - o < 50) ? P - o : 50;
        return (tp >= o) && (tp < o + w);
    endfunction

    function automatic logic [31:0] exp_ch(input int i);
        if (ch_off(i) < 0) return 32'h0;
        return 32'h8000_0000 | 32'(ch_off(i));
    endfunction

    initial begin
        int tp;
        ref_in   = 1'b0;
        piezo_in = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (gen_on) begin
                tp     = ((cyc - base) % P + P) % P;
                ref_in = !ref_stop && (tp < 50);
                for (int i = 0; i < NUM_CH; i++) piezo_in[i] = ch_level(i, tp);
            end
        end
    end

    always @(negedge clk) begin
        mon_cyc++;
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_interval = mon_cyc - fd_last;
            fd_last     = mon_cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        pop_check();
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < budget);
        check(tag, 32'(frame_done === 1'b1), 32'd1);
    endtask

    initial begin
        int fd0;
        reset         = 1'b1;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_address   = '0;
        avs_writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_readdata", avs_readdata, 32'h0);
        check("reset_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        rd(7'h61, 32'h0, "status_after_reset");
        rd(7'h62, 32'h0, "ctrl_after_reset");
        rd(7'h05, 32'h0, "ch5_after_reset");

        wr(7'h62, 32'h1);
        rd(7'h62, 32'h1, "ctrl_enabled");
        rd(7'h61, 32'h2, "status_wait_ref");
        base   = cyc + 1;
        gen_on = 1'b1;

        wait_frame(2 * P + 100, "first_publish");
        for (int i = 0; i < NUM_CH; i++) rd(7'(i), exp_ch(i), $sformatf("ch%0d_frame1", i));
        rd(7'h60, 32'd1250, "period_frame1");
        rd(7'h61, 32'h0001_0004, "status_frame1");
        check("one_pulse_after_two_edges", 32'(fd_count), 32'd1);

        wait_frame(P + 100, "frame2");
        wait_frame(P + 100, "frame3");
        @(negedge clk);
        check("frame_interval", 32'(fd_interval), 32'd1250);
        check("frame_count_3", 32'(fd_count), 32'd3);
        rd(7'h07, 32'h0, "ch7_missing_frame3");
        rd(7'h03, 32'h8000_00C8, "ch3_multi_edge");
        rd(7'h00, 32'h8000_0000, "ch0_coincident");
        rd(7'h61, 32'h0003_0004, "status_frame3");

        ref_stop = 1'b1;
        fd0 = fd_count;
        repeat (66000) @(negedge clk);
        check("no_publish_during_loss", 32'(fd_count - fd0), 32'd0);
        rd(7'h61, 32'h0003_0003, "status_ref_lost");
        rd(7'h05, 32'h8000_0064, "ch5_held_loss");
        rd(7'h58, 32'h8000_04E1, "ch88_held_loss");
        rd(7'h60, 32'd1250, "period_held_loss");

        base     = cyc + 1;
        ref_stop = 1'b0;
        fd0 = fd_count;
        repeat (P - 50) @(negedge clk);
        check("no_publish_first_edge", 32'(fd_count - fd0), 32'd0);
        wait_frame(200, "publish_second_edge");
        rd(7'h61, 32'h0004_0005, "status_after_restart");
        check("one_publish_after_restart", 32'(fd_count - fd0), 32'd1);
        rd(7'h05, 32'h8000_0064, "ch5_after_restart");
        rd(7'h58, 32'h8000_04E1, "ch88_after_restart");

        wr(7'h62, 32'h3);
        rd(7'h61, 32'h0000_0004, "status_after_clear");
        rd(7'h62, 32'h1, "ctrl_clear_self_clears");

        rd(7'h70, 32'h0, "unmapped_0x70");
        rd(7'h59, 32'h0, "beyond_last_ch");
        wr(7'h05, 32'hFFFF_FFFF);
        rd(7'h05, 32'h8000_0064, "ch5_write_ignored");
        wr(7'h60, 32'h0000_1234);
        rd(7'h60, 32'd1250, "period_write_ignored");

        exp_q.push_back(32'h8000_0064); tag_q.push_back("b2b_first");
        exp_q.push_back(32'h8000_04E1); tag_q.push_back("b2b_second");
        avs_address = 7'h05;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_address = 7'h58;
        pop_check();
        @(negedge clk);
        avs_read    = 1'b0;
        pop_check();

        exp_q.push_back(32'h1); tag_q.push_back("rw_same_cycle");
        avs_address   = 7'h62;
        avs_writedata = 32'h0;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        pop_check();
        fd0 = fd_count;
        repeat (1500) @(negedge clk);
        check("no_publish_disabled", 32'(fd_count - fd0), 32'd0);
        rd(7'h61, 32'h0, "status_idle");
        rd(7'h05, 32'h8000_0064, "ch5_held_disabled");
        rd(7'h60, 32'd1250, "period_held_disabled");
        rd(7'h62, 32'h0, "ctrl_disabled");

        wr(7'h62, 32'h1);
        wait_frame(2 * P + 100, "publish_after_reenable");
        rd(7'h05, 32'h8000_0064, "ch5_before_reset");
        repeat (300) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midwin_reset_readdata", avs_readdata, 32'h0);
        check("midwin_reset_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        rd(7'h05, 32'h0, "ch5_after_midwin_reset");
        rd(7'h58, 32'h0, "ch88_after_midwin_reset");
        rd(7'h60, 32'h0, "period_after_midwin_reset");
        rd(7'h61, 32'h0, "status_after_midwin_reset");
        rd(7'h62, 32'h0, "ctrl_after_midwin_reset");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/piezo_phase_monitor.md
Name: piezo_phase_monitor

Overview:
Receive-side counterpart of the piezo controller. Samples the NUM_CH piezo drive lines fed back from the transducer array, plus the reference strobe from the clock divider. Measures each channel's rising-edge phase offset against the reference, in system clock cycles. Results are double-buffered and exposed to the HPS through an Avalon-MM slave for closed-loop phase verification.

Parameters:
NUM_CH, 89, number of monitored piezo channels (max 96)
CNT_W, 16, width of period/phase counter (max 16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
piezo_in  in  NUM_CH  asynchronous piezo feedback lines
ref_in  in  1  asynchronous reference strobe, one rising edge per drive period
avs_address  in  7  word address
avs_read  in  1  read strobe
avs_readdata  out  32  read data, valid 1 cycle after avs_read
avs_write  in  1  write strobe
avs_writedata  in  32  write data
frame_done  out  1  1-cycle pulse on each publish

Behaviour:
- Reset:
  - avs_readdata, frame_done, counters, capture and published banks, flags all 0.
  - enable=0.
- Input sync:
  - piezo_in and ref_in each pass through a 2-FF synchroniser, then a registered rising-edge detect (ch_rise[i], ref_rise).
  - Both paths see identical delay, so it cancels in the phase result.
- Counter cnt (CNT_W):
  - Loads 0 on ref_rise; otherwise increments each clk while enable=1.
  - On reaching 2^CNT_W-1 while armed: set sticky ref_lost, clear armed and all seen[i], hold cnt at 0 until the next ref_rise.
- States: IDLE (enable=0), WAIT_REF (enabled, not armed), MEASURE (armed).
  - IDLE -> WAIT_REF on enable=1.
  - WAIT_REF -> MEASURE on ref_rise, with no publish.
  - MEASURE -> MEASURE on ref_rise, with publish.
  - MEASURE -> WAIT_REF on saturation.
  - Any state -> IDLE on enable=0; this clears seen, armed and cnt, and holds the published bank.
- Capture: in MEASURE, first ch_rise[i] with seen[i]=0 stores cap[i]<=cnt and sets seen[i]. Later edges in the same window are ignored.
- Publish on ref_rise in MEASURE:
  - phase_pub[i]<=cap[i]; valid_pub[i]<=seen[i]; period_pub<=cnt+1.
  - frame_cnt+=1 (16 bit, wraps); frame_done=1 that cycle; seen cleared.
- Simultaneous ch_rise[i] and ref_rise:
  - The edge belongs to the new window, captured as phase 0.
  - The old window's seen[i] value is what gets published.
- Register map (reads, 1-cycle latency):
  - 0..NUM_CH-1: {valid_pub[i], 15'b0, phase_pub[i] zero-extended to 16}.
  - 0x60: period_pub.
  - 0x61: {frame_cnt[15:0], 13'b0, state[1:0], ref_lost}.
  - 0x62: {30'b0, 1'b0, enable}.
  - Other addresses read 0.
  - A read of any address has no side effects.
- Writes:
  - 0x62 bit0 sets enable.
  - 0x62 bit1=1 clears ref_lost and frame_cnt. Bit1 is self-clearing and reads as 0.
  - Writes to other addresses are ignored.
  - Simultaneous read and write: the read returns the pre-write value.
- Reset mid-window: everything is forced to reset values immediately; no partial publish.

Decomposition:
- Package piezo_mon_pkg holds:
  - Register address constants: ADDR_PERIOD=0x60, ADDR_STATUS=0x61, ADDR_CTRL=0x62.
  - State enum: IDLE/WAIT_REF/MEASURE.
  - Readdata field positions.
- Sub-module piezo_mon_channel, instantiated NUM_CH times:
  - Contains synchroniser, edge detect, seen flag, cap register and published phase/valid.
  - Inputs: cnt, ref_rise, armed, clear.

Test Plan:
- Basic phase:
  - Stimulus: enable, ref period 1250 clk; channel 5 rising 100 clk after ref; channels 0 and 88 at 0 and 1249 clk.
  - Required after 2nd ref edge: addr 5 = 0x80000064; addr 0 = 0x80000000; addr 88 = 0x800004E1.
  - Required also: addr 0x60 = 1250; frame_done pulses once per period.
- Missing channel:
  - Stimulus: channel 7 held low.
  - Required: addr 7 bit31=0 every frame; other channels valid.
- Multiple edges:
  - Stimulus: channel 3 toggled at 200 and 600 clk.
  - Required: phase 200.
  - Stimulus: channel edge on the same synced cycle as ref.
  - Required: next frame phase 0.
- Ref loss:
  - Stimulus: stop ref for >65535 clk.
  - Required: status ref_lost=1, state=WAIT_REF, published bank unchanged.
  - Stimulus: restart ref.
  - Required: first publish occurs only on the 2nd edge.
  - Stimulus: write 0x62=0x3.
  - Required: ref_lost=0, frame_cnt=0.
- Disable/reset:
  - Stimulus: enable=0 mid-window.
  - Required: no frame_done; bank held; state=IDLE.
  - Stimulus: assert reset mid-window.
  - Required: all reads 0 and frame_done=0 on the next cycle.
- Bus:
  - Stimulus: read addr 0x70.
  - Required: 0.
  - Stimulus: back-to-back reads.
  - Required: data valid 1 cycle after each strobe.
  - Stimulus: write to addr 5.
  - Required: no effect.
